// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// per-class latencies and the controller state encoding.
// No logic lives here; everything is consumed by mdu_arith and mul_div_unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purpose: combinational 32x32 multiply (signed/unsigned) and divide (signed/unsigned).
// Latency: zero cycles, pure combinational; the owning FSM supplies the architectural delay.
// Backpressure: none; o_wr low tells the caller a divide-by-zero must not update HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_wr
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Products: the low 64 bits of a 64x64 product of extended operands are exact.
    assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Divide on magnitudes, then restore signs. 0x80000000 negates to itself,
    // which as an unsigned magnitude is exactly 2^31, so the overflow case
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign w_a_neg   = (i_op == OP_DIV) && i_rs[31];
    assign w_b_neg   = (i_op == OP_DIV) && i_rt[31];
    assign w_a_mag   = w_a_neg ? (~i_rs + 32'd1) : i_rs;
    assign w_b_mag   = w_b_neg ? (~i_rt + 32'd1) : i_rt;
    // Steer a zero divisor away from the divider; the result is discarded anyway.
    assign w_den     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quo     = w_a_mag / w_den;
    assign w_rem     = w_a_mag % w_den;
    assign w_quo_fix = (w_a_neg ^ w_b_neg) ? (~w_quo + 32'd1) : w_quo;
    assign w_rem_fix = w_a_neg ? (~w_rem + 32'd1) : w_rem;

    // Result select per operation; only long ops produce a writable result.
    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        o_wr = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_hi = w_prod_s[63:32];
                o_lo = w_prod_s[31:0];
                o_wr = 1'b1;
            end
            OP_MULTU: begin
                o_hi = w_prod_u[63:32];
                o_lo = w_prod_u[31:0];
                o_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_hi = w_rem_fix;
                o_lo = w_quo_fix;
                o_wr = (i_rt != 32'd0);
            end
            default: begin
                o_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Purpose: MIPS-style HI/LO unit; MULT/MULTU take 5 cycles, DIV/DIVU 10, MTHI/MTLO write on the issue edge.
// Latency: busy rises the edge after issue, stays high N cycles; HI/LO are new in the first non-busy cycle.
// Backpressure: busy asks the hazard unit to stall; starts seen while busy are dropped. Optional MDU_CANCEL_EN adds a flush input.
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_tmp_hi;
    logic [31:0] r_tmp_lo;
    logic        r_tmp_wr;

    mdu_op_e     w_op;
    logic        w_cancel;
    logic        w_accept;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_finish;
    logic        w_abort;
    logic [3:0]  w_lat;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    assign w_op = mdu_op_e'(mdu_op);

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_lat = ((w_op == OP_MULT) || (w_op == OP_MULTU)) ? MULT_CYCLES : DIV_CYCLES;

    mdu_arith u_arith (
        .i_op (w_op),
        .i_rs (rs_val),
        .i_rt (rt_val),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo),
        .o_wr (w_res_wr)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle strobes: issue, move-to, completion, flush.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_cancel) begin
                    if (is_long_op(w_op)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                    w_mthi = (w_op == OP_MTHI);
                    w_mtlo = (w_op == OP_MTLO);
                end
            end
            ST_RUN: begin
                if (w_cancel) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter, staged result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_tmp_wr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt    <= w_lat;
                r_tmp_hi <= w_res_hi;
                r_tmp_lo <= w_res_lo;
                r_tmp_wr <= w_res_wr;
            end else if (r_state == ST_RUN) begin
                r_cnt <= w_abort ? 4'd0 : (r_cnt - 4'd1);
            end
            if (w_mthi) begin
                r_hi <= rs_val;
            end
            if (w_mtlo) begin
                r_lo <= rs_val;
            end
            if (w_finish && r_tmp_wr) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = rd_sel ? r_hi : r_lo;

endmodule
